// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter with a destination-register busy scoreboard.
// NREQ writeback producers share a single register-file write port. The grant is
// round-robin and combinational, and the write reaches the register file one
// cycle later. The scoreboard marks every destination register that has a write
// in flight. The issue stage reads it through the hazard flag.
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_rd,
    input  logic [NREQ*XLEN-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 issue_valid,
    input  logic [AW-1:0]        issue_rd,
    input  logic [AW-1:0]        issue_rs1,
    input  logic [AW-1:0]        issue_rs2,
    output logic                 hazard,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_rd,
    output logic [XLEN-1:0]      rf_wdata,
    output logic [2**AW-1:0]     busy
);

    localparam int NREG = 2**AW;
    localparam int PW   = $clog2(NREQ);
    localparam int SW   = PW + 1;

    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   rr_ptr_next;
    logic [PW-1:0]   grant_idx;
    logic            grant_any;
    logic [SW-1:0]   scan;
    logic [AW-1:0]   grant_rd;
    logic [XLEN-1:0] grant_data;
    logic [NREG-1:0] busy_next;
    logic            issue_set;

    // Round-robin pick: walk from rr_ptr upward, wrap at NREQ, grant first valid
    always_comb begin
        req_ready = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        scan      = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, rr_ptr} + SW'(k);
            if (scan >= SW'(NREQ)) begin
                scan = scan - SW'(NREQ);
            end
            if (!grant_any && req_valid[scan[PW-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = scan[PW-1:0];
            end
        end
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Pointer moves to the requester just after the winner; holds when idle
    always_comb begin
        rr_ptr_next = rr_ptr;
        if (grant_any) begin
            if (grant_idx == PW'(NREQ - 1)) begin
                rr_ptr_next = '0;
            end else begin
                rr_ptr_next = grant_idx + 1'b1;
            end
        end
    end

    // Mux the winning requester's destination and data off the one-hot grant
    always_comb begin
        grant_rd   = '0;
        grant_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                grant_rd   = req_rd[i*AW +: AW];
                grant_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    assign issue_set = issue_valid && (issue_rd != '0);

    // Scoreboard update: clear on writeback, then set on issue so a newer
    // producer of the same register stays pending; x0 never becomes busy
    always_comb begin
        busy_next = busy;
        if (grant_any) begin
            busy_next[grant_rd] = 1'b0;
        end
        if (issue_set) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Hazard looks at the current scoreboard only, so a register being written
    // back this cycle still stalls; x0 operands never stall
    always_comb begin
        hazard = ((issue_rs1 != '0) && busy[issue_rs1]) ||
                 ((issue_rs2 != '0) && busy[issue_rs2]) ||
                 ((issue_rd  != '0) && busy[issue_rd]);
    end

    // Arbitration pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_ptr_next;
        end
    end

    // Registered write port; an x0 grant loads address/data but never enables
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else if (grant_any) begin
            rf_we    <= (grant_rd != '0);
            rf_rd    <= grant_rd;
            rf_wdata <= grant_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    // Busy scoreboard register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter. A scoreboard queue holds the expected
// register-file writes. Scenario tasks check grants, hazard and busy inline.
module tb_regfile_wb_arbiter;

    localparam int NREQ = 3;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wr_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_rd;
    logic [NREQ*XLEN-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 issue_valid;
    logic [AW-1:0]        issue_rd;
    logic [AW-1:0]        issue_rs1;
    logic [AW-1:0]        issue_rs2;
    logic                 hazard;
    logic                 rf_we;
    logic [AW-1:0]        rf_rd;
    logic [XLEN-1:0]      rf_wdata;
    logic [2**AW-1:0]     busy;

    int   checks = 0;
    int   errors = 0;
    int   m_rr   = 0;
    wr_t  exp_q[$];
    wr_t  mon_e;

    regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_rd      (req_rd),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .hazard      (hazard),
        .rf_we       (rf_we),
        .rf_rd       (rf_rd),
        .rf_wdata    (rf_wdata),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every enabled write must match the oldest expected one
    always @(posedge clk) begin
        #1;
        if (rst_n === 1'b1 && rf_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_write: got rd=%0d data=%h, required no write", rf_rd, rf_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (rf_rd !== mon_e.rd || rf_wdata !== mon_e.data) begin
                    errors++;
                    $display("FAIL sb_write: got rd=%0d data=%h, required rd=%0d data=%h",
                             rf_rd, rf_wdata, mon_e.rd, mon_e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int i, input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
        req_rd[i*AW +: AW]       = rd;
        req_data[i*XLEN +: XLEN] = d;
    endtask

    task automatic clear_inputs();
        req_valid   = '0;
        req_rd      = '0;
        req_data    = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        issue_rs1   = '0;
        issue_rs2   = '0;
    endtask

    // Predict this cycle's grant from the reference round-robin, queue the
    // expected write, then advance to just after the clock edge
    task automatic tick();
        int g;
        int idx;
        logic [AW-1:0] rd;
        wr_t w;
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            idx = (m_rr + k) % NREQ;
            if (g < 0 && req_valid[idx]) g = idx;
        end
        if (g >= 0) begin
            rd = req_rd[g*AW +: AW];
            if (rd != '0) begin
                w.rd   = rd;
                w.data = req_data[g*XLEN +: XLEN];
                exp_q.push_back(w);
            end
            m_rr = (g + 1) % NREQ;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        m_rr = 0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        clear_inputs();
        #1;
        rst_n = 1'b0;
        #2;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %b, required 0", rf_we); end
        checks++; if (rf_rd !== '0) begin errors++; $display("FAIL reset_rf_rd: got %0d, required 0", rf_rd); end
        checks++; if (rf_wdata !== '0) begin errors++; $display("FAIL reset_rf_wdata: got %h, required 0", rf_wdata); end
        checks++; if (busy !== '0) begin errors++; $display("FAIL reset_busy: got %h, required 0", busy); end
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b, required 000", req_ready); end
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %b, required 0", hazard); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_rr = 0;
    endtask

    task automatic test_single();
        set_req(0, 5'd5, 32'hDEADBEEF);
        req_valid = 3'b001;
        @(negedge clk);
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL single_ready: got %b, required 001", req_ready); end
        tick();
        req_valid = 3'b000;
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL single_we: got %b, required 1", rf_we); end
        checks++; if (rf_rd !== 5'd5) begin errors++; $display("FAIL single_rd: got %0d, required 5", rf_rd); end
        checks++; if (rf_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data: got %h, required deadbeef", rf_wdata); end
        @(negedge clk);
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL idle_ready: got %b, required 000", req_ready); end
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL idle_we: got %b, required 0", rf_we); end
        checks++; if (rf_rd !== 5'd5) begin errors++; $display("FAIL idle_rd_hold: got %0d, required 5", rf_rd); end
    endtask

    task automatic test_round_robin();
        int exp_g[6] = '{0, 1, 2, 0, 1, 2};
        logic [NREQ-1:0] want;
        apply_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 5'(10 + i), 32'hA000_0000 + 32'(i));
        req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            want = 3'b001 << exp_g[c];
            @(negedge clk);
            checks++; if (req_ready !== want) begin errors++; $display("FAIL rr_grant%0d: got %b, required %b", c, req_ready, want); end
            tick();
            checks++; if (rf_we !== 1'b1 || rf_rd !== 5'(10 + exp_g[c])) begin
                errors++; $display("FAIL rr_write%0d: got we=%b rd=%0d, required we=1 rd=%0d", c, rf_we, rf_rd, 10 + exp_g[c]);
            end
            set_req(exp_g[c], 5'(10 + exp_g[c]), 32'hA000_0000 + 32'(16 * (c + 1) + exp_g[c]));
        end
        req_valid = 3'b000;
        tick();
    endtask

    task automatic test_hazard();
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        @(negedge clk);
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL hz_before_issue: got %b, required 0", hazard); end
        tick();
        issue_valid = 1'b0;
        issue_rd    = 5'd0;
        issue_rs1   = 5'd7;
        @(negedge clk);
        checks++; if (busy[7] !== 1'b1) begin errors++; $display("FAIL hz_busy_set: got %b, required 1", busy[7]); end
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL hz_rs1: got %b, required 1", hazard); end
        tick();
        issue_rs1 = 5'd0;
        issue_rs2 = 5'd7;
        @(negedge clk);
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL hz_rs2: got %b, required 1", hazard); end
        tick();
        issue_rs2 = 5'd0;
        issue_rd  = 5'd7;
        set_req(1, 5'd7, 32'h0000_0777);
        req_valid = 3'b010;
        @(negedge clk);
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL hz_wb_ready: got %b, required 010", req_ready); end
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL hz_rd_same_cycle: got %b, required 1", hazard); end
        tick();
        req_valid = 3'b000;
        issue_rd  = 5'd0;
        issue_rs1 = 5'd7;
        checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd7) begin errors++; $display("FAIL hz_write: got we=%b rd=%0d, required we=1 rd=7", rf_we, rf_rd); end
        @(negedge clk);
        checks++; if (busy[7] !== 1'b0) begin errors++; $display("FAIL hz_busy_clear: got %b, required 0", busy[7]); end
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL hz_released: got %b, required 0", hazard); end
        tick();
        issue_rs1 = 5'd0;
    endtask

    task automatic test_set_wins();
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        tick();
        set_req(2, 5'd9, 32'h0000_0099);
        req_valid = 3'b100;
        @(negedge clk);
        checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL sw_ready: got %b, required 100", req_ready); end
        tick();
        issue_valid = 1'b0;
        issue_rd    = 5'd0;
        req_valid   = 3'b000;
        checks++; if (busy[9] !== 1'b1) begin errors++; $display("FAIL sw_busy9: got %b, required 1", busy[9]); end
        checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd9) begin errors++; $display("FAIL sw_write: got we=%b rd=%0d, required we=1 rd=9", rf_we, rf_rd); end
        set_req(0, 5'd9, 32'h0000_0999);
        req_valid = 3'b001;
        @(negedge clk);
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL sw_wrap_ready: got %b, required 001", req_ready); end
        tick();
        req_valid = 3'b000;
        checks++; if (busy !== '0) begin errors++; $display("FAIL sw_busy_drained: got %h, required 0", busy); end
    endtask

    task automatic test_x0_write();
        issue_valid = 1'b1;
        issue_rd    = 5'd3;
        tick();
        issue_valid = 1'b0;
        issue_rd    = 5'd0;
        set_req(1, 5'd0, 32'h0000_1234);
        req_valid = 3'b010;
        @(negedge clk);
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL x0_ready: got %b, required 010", req_ready); end
        tick();
        req_valid = 3'b000;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_we: got %b, required 0", rf_we); end
        checks++; if (busy !== 32'h0000_0008) begin errors++; $display("FAIL x0_busy: got %h, required 00000008", busy); end
        checks++; if (rf_rd !== 5'd0 || rf_wdata !== 32'h0000_1234) begin
            errors++; $display("FAIL x0_latch: got rd=%0d data=%h, required rd=0 data=00001234", rf_rd, rf_wdata);
        end
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_after_we: got %b, required 0", rf_we); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int r = 4; r < 8; r++) begin
            issue_valid = 1'b1;
            issue_rd    = 5'(r);
            if (r == 7) begin
                set_req(0, 5'd20, 32'hCAFEF00D);
                req_valid = 3'b001;
            end
            tick();
        end
        clear_inputs();
        checks++; if (busy !== 32'h0000_00F0) begin errors++; $display("FAIL ar_busy_pre: got %h, required 000000f0", busy); end
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL ar_we_pre: got %b, required 1", rf_we); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== '0) begin errors++; $display("FAIL ar_busy: got %h, required 0", busy); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL ar_we: got %b, required 0", rf_we); end
        checks++; if (rf_rd !== '0 || rf_wdata !== '0) begin errors++; $display("FAIL ar_port: got rd=%0d data=%h, required 0", rf_rd, rf_wdata); end
        m_rr = 0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 5'(16 + i), 32'h5000_0000 + 32'(i));
        req_valid = 3'b111;
        @(negedge clk);
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL ar_rr_ptr: got %b, required 001", req_ready); end
        tick();
        req_valid = 3'b000;
        tick();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_hazard();
        test_set_wins();
        test_x0_write();
        test_async_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d writes still expected, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
